// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module  : debounce_pkg
// Purpose : Shared types and helpers for the push-button debouncer and any
//           later input-conditioning blocks that track a debounced state.
// Contents: db_state_t    - four-state debounce FSM encoding
//           cnt_width()   - width of a counter able to hold 0..stable_cycles
//           is_high_state - debounced level implied by an FSM state
// Revision: 1.0 - initial release
// ============================================================================
package debounce_pkg;

  typedef enum logic [1:0] {
    RELEASED        = 2'd0,
    PRESS_PENDING   = 2'd1,
    PRESSED         = 2'd2,
    RELEASE_PENDING = 2'd3
  } db_state_t;

  function automatic int cnt_width(input int stable_cycles);
    return $clog2(stable_cycles + 1);
  endfunction

  // The accepted level only flips once a pending state resolves, so a
  // release that is still pending keeps the button reported as pressed.
  function automatic logic is_high_state(input db_state_t s);
    return (s == PRESSED) || (s == RELEASE_PENDING);
  endfunction

endpackage
`default_nettype wire

// File: rtl/button_debouncer_sync_chain.sv
`default_nettype none
// ============================================================================
// Module  : sync_chain
// Purpose : Generic multi-flop synchronizer bringing an asynchronous single-bit
//           input into the clock domain. Async-reset to zero.
// Params  : STAGES  - number of flip-flops in the chain (>= 2)
// Ports   : clock   in  1  sampling clock (posedge)
//           reset   in  1  asynchronous, active-high, clears the chain
//           d_i     in  1  asynchronous input
//           q_o     out 1  synchronized output (last stage)
// Revision: 1.0 - initial release
// ============================================================================
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module  : button_debouncer
// Purpose : Turns a raw, bouncing, asynchronous push-button into a clean
//           debounced level plus single-cycle press / release pulses.
// Params  : SYNC_STAGES    - synchronizer depth (>= 2)
//           STABLE_CYCLES  - identical synchronized samples needed to accept
//                            a change (>= 1)
// Ports   : clock        in  1  system clock (posedge)
//           reset        in  1  asynchronous, active-high
//           btn_in       in  1  raw button input
//           btn_level    out 1  debounced level (registered)
//           btn_press    out 1  one-cycle pulse on accepted 0->1 (registered)
//           btn_release  out 1  one-cycle pulse on accepted 1->0 (registered)
// Revision: 1.0 - initial release
// ============================================================================
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam int            CW       = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam bit            SINGLE   = (STABLE_CYCLES == 1);

  logic          btn_sync;
  db_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clock (clock),
    .reset (reset),
    .d_i   (btn_in),
    .q_o   (btn_sync)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= RELEASED;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RELEASED: begin
        if (btn_sync) begin
          // With a one-sample stability window the first sample is enough.
          if (SINGLE) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else begin
            state_d = PRESS_PENDING;
            cnt_d   = CNT_ONE;
          end
        end
      end
      PRESS_PENDING: begin
        if (!btn_sync) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!btn_sync) begin
          if (SINGLE) begin
            state_d = RELEASED;
            cnt_d   = '0;
          end else begin
            state_d = RELEASE_PENDING;
            cnt_d   = CNT_ONE;
          end
        end
      end
      RELEASE_PENDING: begin
        if (btn_sync) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  // Pulses fire only when the accepted level actually flips; a bounce that
  // falls back from a pending state leaves the level untouched.
  always_comb begin
    level_d   = is_high_state(state_d);
    press_d   = !is_high_state(state_q) && (state_d == PRESSED);
    release_d = is_high_state(state_q) && (state_d == RELEASED);
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

endmodule
`default_nettype wire

// File: tb/tb_button_debouncer.sv
`default_nettype none
// ============================================================================
// Module  : tb_button_debouncer
// Purpose : Self-checking bench for button_debouncer. A run-length model of
//           the debounce rule is compared against the DUT on every cycle, and
//           directed scenarios pin latency and pulse counts with literals.
// Revision: 1.0 - initial release
// ============================================================================
module tb_button_debouncer;

  localparam int SYNC   = 2;
  localparam int STABLE = 4;

  logic clock = 1'b0;
  logic reset;
  logic btn_in;
  logic btn_level, btn_press, btn_release;

  int checks    = 0;
  int errors    = 0;
  int press_cnt = 0;
  int rel_cnt   = 0;
  logic [1:0] ctr2 = 2'd0;

  button_debouncer #(
    .SYNC_STAGES   (SYNC),
    .STABLE_CYCLES (STABLE)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .btn_in      (btn_in),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release)
  );

  always #50 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: the input seen by the debounce rule is btn_in delayed by SYNC
  // sampling edges; the level flips once STABLE consecutive samples
  // disagree with it, and any agreeing sample restarts that run.
  logic [SYNC-1:0] m_sh    = '0;
  logic            m_level = 1'b0;
  int              m_run   = 0;
  logic            m_press = 1'b0;
  logic            m_rel   = 1'b0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_sh    <= '0;
      m_level <= 1'b0;
      m_run   <= 0;
      m_press <= 1'b0;
      m_rel   <= 1'b0;
    end else begin : model_step
      logic s;
      int   run;
      logic lvl, p, r;
      s   = m_sh[SYNC-1];
      run = m_run;
      lvl = m_level;
      p   = 1'b0;
      r   = 1'b0;
      if (s != lvl) begin
        run++;
        if (run == STABLE) begin
          lvl = s;
          p   = s;
          r   = !s;
          run = 0;
        end
      end else begin
        run = 0;
      end
      m_sh    <= {m_sh[SYNC-2:0], btn_in};
      m_level <= lvl;
      m_run   <= run;
      m_press <= p;
      m_rel   <= r;
    end
  end

  always @(negedge clock) begin
    chk("level_vs_model",   32'(btn_level),   32'(m_level));
    chk("press_vs_model",   32'(btn_press),   32'(m_press));
    chk("release_vs_model", 32'(btn_release), 32'(m_rel));
    if (btn_press) begin
      press_cnt++;
      ctr2 = ctr2 + 2'd1;
    end
    if (btn_release) rel_cnt++;
  end

  // Inputs change 10 ns after the falling edge, clear of both sampling points.
  task automatic step();
    @(negedge clock);
    #10;
  endtask

  int p0, r0;

  initial begin
    reset  = 1'b1;
    btn_in = 1'b0;

    // Reset
    step();
    chk("reset_level",   32'(btn_level),   0);
    chk("reset_press",   32'(btn_press),   0);
    chk("reset_release", 32'(btn_release), 0);
    reset = 1'b0;
    repeat (3) step();
    chk("idle_level", 32'(btn_level), 0);

    // Clean press: level rises after the 6th edge
    p0 = press_cnt; r0 = rel_cnt;
    btn_in = 1'b1;
    repeat (5) step();
    chk("press_lat_level_5", 32'(btn_level), 0);
    chk("press_lat_press_5", 32'(btn_press), 0);
    step();
    chk("press_lat_level_6", 32'(btn_level), 1);
    chk("press_lat_press_6", 32'(btn_press), 1);
    step();
    chk("press_one_cycle", 32'(btn_press), 0);
    repeat (5) step();
    chk("press_count_clean", 32'(press_cnt - p0), 1);
    chk("release_none_on_press", 32'(rel_cnt - r0), 0);

    // Clean release
    p0 = press_cnt; r0 = rel_cnt;
    btn_in = 1'b0;
    repeat (5) step();
    chk("rel_lat_level_5", 32'(btn_level), 1);
    step();
    chk("rel_lat_level_6",   32'(btn_level),   0);
    chk("rel_lat_release_6", 32'(btn_release), 1);
    chk("rel_lat_press_6",   32'(btn_press),   0);
    step();
    chk("release_one_cycle", 32'(btn_release), 0);
    chk("release_count", 32'(rel_cnt - r0), 1);
    chk("press_none_on_release", 32'(press_cnt - p0), 0);

    // Bounce: 3 high / 1 low, five times, then held
    p0 = press_cnt;
    repeat (5) begin
      btn_in = 1'b1;
      repeat (3) step();
      btn_in = 1'b0;
      step();
    end
    chk("bounce_no_press", 32'(press_cnt - p0), 0);
    chk("bounce_level",    32'(btn_level),      0);
    btn_in = 1'b1;
    repeat (10) step();
    chk("bounce_one_press", 32'(press_cnt - p0), 1);
    chk("bounce_level_end", 32'(btn_level),      1);

    btn_in = 1'b0;
    repeat (10) step();
    chk("bounce_released", 32'(btn_level), 0);

    // Reset while a press is pending
    p0 = press_cnt;
    btn_in = 1'b1;
    repeat (3) step();
    chk("pending_level", 32'(btn_level), 0);
    reset = 1'b1;
    step();
    chk("midrst_level",   32'(btn_level),   0);
    chk("midrst_press",   32'(btn_press),   0);
    chk("midrst_release", 32'(btn_release), 0);
    reset = 1'b0;
    repeat (5) step();
    chk("postrst_level_5", 32'(btn_level), 0);
    step();
    chk("postrst_level_6", 32'(btn_level), 1);
    chk("postrst_press_6", 32'(btn_press), 1);
    step();
    chk("postrst_press_count", 32'(press_cnt - p0), 1);

    // Four press/release pairs driving a 2-bit counter enable
    btn_in = 1'b0;
    repeat (10) step();
    ctr2 = 2'd0;
    p0 = press_cnt; r0 = rel_cnt;
    repeat (4) begin
      btn_in = 1'b1;
      repeat (10) step();
      btn_in = 1'b0;
      repeat (10) step();
    end
    chk("pairs_press_count",   32'(press_cnt - p0), 4);
    chk("pairs_release_count", 32'(rel_cnt - r0),   4);
    chk("pairs_counter_wrap",  32'(ctr2),           0);
    chk("pairs_level_end",     32'(btn_level),      0);

    if (errors == 0) $display("Test passed");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
